// File: rtl/z80_bus_arbiter_if.sv
// Purpose: bundles the shared-bus handshake between the arbiter, the Z80
//          nBUSRQ/nBUSACK pins and the DMA requesters.
// Signals: req (requester -> arbiter), gnt (one-hot grant), nBUSRQ (to CPU),
//          nBUSACK (from CPU), bus_own (external bus driver enable).
// Modports: master = arbiter side, slave = CPU/requester side.
interface z80_bus_arbiter_if #(
    parameter int NREQ = 2
) ();
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            nBUSRQ;
    logic            nBUSACK;
    logic            bus_own;

    modport master (
        input  req,
        input  nBUSACK,
        output gnt,
        output nBUSRQ,
        output bus_own
    );

    modport slave (
        output req,
        output nBUSACK,
        input  gnt,
        input  nBUSRQ,
        input  bus_own
    );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Purpose: shares the Z80 external bus between the CPU and NREQ DMA requesters
//          via nBUSRQ/nBUSACK, with round robin, burst limit, turnaround and CPU slot.
// Latency: every output registered; one cycle from a sampled input to its effect.
// Backpressure: requesters hold req until done; the block waits in REQ indefinitely for nBUSACK.
// Ports: CLK, RESET (async, active high); bus.master carries req/gnt/nBUSRQ/nBUSACK/bus_own.
module z80_bus_arbiter #(
    parameter int NREQ        = 2,
    parameter int MAX_BURST   = 16,
    parameter int TURN_CYCLES = 1,
    parameter int CPU_SLOT    = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    z80_bus_arbiter_if.master     bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW   = $clog2(MAX_BURST + 1);
    localparam int TW   = $clog2(TURN_CYCLES + 1);
    localparam int SW   = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;

    localparam logic [IDXW:0]   NREQ_W   = (IDXW + 1)'(NREQ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);
    localparam logic [BW-1:0]   BURST_MX = BW'(MAX_BURST);
    localparam logic [TW-1:0]   TURN_MX  = TW'(TURN_CYCLES);
    localparam logic [SW-1:0]   SLOT_LD  = SW'(CPU_SLOT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_TURN,
        ST_RELEASE
    } state_t;

    state_t            state_q,   state_d;
    logic              nbusrq_q,  nbusrq_d;
    logic [NREQ-1:0]   gnt_q,     gnt_d;
    logic              bus_own_q, bus_own_d;
    logic [IDXW-1:0]   own_q,     own_d;      // current / last owner index
    logic [IDXW-1:0]   rr_ptr_q,  rr_ptr_d;   // highest-priority index for the next contest
    logic [BW-1:0]     burst_q,   burst_d;    // grant cycles used in this tenure
    logic [TW-1:0]     turn_q,    turn_d;     // turnaround cycles elapsed
    logic [SW-1:0]     slot_q,    slot_d;     // CPU cycles still owed before re-request
    logic              expired_q, expired_d;  // last tenure hit the burst limit

    // Round-robin winner: rotate req so rr_ptr sits at bit 0, take the lowest
    // set bit, then rotate the offset back into an absolute index.
    logic [NREQ-1:0] req_rot;
    logic [IDXW:0]   win_sum;
    logic [IDXW-1:0] win_idx;
    logic            win_found;

    always_comb begin
        req_rot   = NREQ'({bus.req, bus.req} >> rr_ptr_q);
        win_found = 1'b0;
        win_sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, rr_ptr_q} + (IDXW + 1)'(k);
            end
        end
        if (win_sum >= NREQ_W) begin
            win_sum = win_sum - NREQ_W;
        end
        win_idx = win_sum[IDXW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        nbusrq_d  = nbusrq_q;
        gnt_d     = gnt_q;
        bus_own_d = bus_own_q;
        own_d     = own_q;
        rr_ptr_d  = rr_ptr_q;
        burst_d   = burst_q;
        turn_d    = turn_q;
        slot_d    = slot_q;
        expired_d = expired_q;

        case (state_q)
            ST_IDLE: begin
                // Requests are ignored until the CPU has had its guaranteed slot.
                if (slot_q != '0) begin
                    slot_d = slot_q - 1'b1;
                end else if (|bus.req) begin
                    state_d  = ST_REQ;
                    nbusrq_d = 1'b0;
                end
            end

            ST_REQ: begin
                // The contest is decided at the ack, not at the original request.
                if (!bus.nBUSACK) begin
                    if (win_found) begin
                        state_d   = ST_GRANT;
                        gnt_d     = NREQ'(1) << win_idx;
                        bus_own_d = 1'b1;
                        own_d     = win_idx;
                        burst_d   = BW'(1);
                    end else begin
                        state_d  = ST_RELEASE;
                        nbusrq_d = 1'b1;
                    end
                end
            end

            ST_GRANT: begin
                // A voluntary drop takes precedence over expiry when both
                // happen on the same cycle, which lets the bus chain onward.
                if (!bus.req[own_q] || (burst_q == BURST_MX)) begin
                    state_d   = ST_TURN;
                    gnt_d     = '0;
                    expired_d = bus.req[own_q];
                    rr_ptr_d  = (own_q == LAST_IDX) ? '0 : own_q + 1'b1;
                    turn_d    = TW'(1);
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end

            ST_TURN: begin
                if (turn_q == TURN_MX) begin
                    if (!expired_q && win_found) begin
                        state_d = ST_GRANT;
                        gnt_d   = NREQ'(1) << win_idx;
                        own_d   = win_idx;
                        burst_d = BW'(1);
                    end else begin
                        state_d   = ST_RELEASE;
                        nbusrq_d  = 1'b1;
                        bus_own_d = 1'b0;
                    end
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (bus.nBUSACK) begin
                    state_d = ST_IDLE;
                    slot_d  = SLOT_LD;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                nbusrq_d  = 1'b1;
                gnt_d     = '0;
                bus_own_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            nbusrq_q  <= 1'b1;
            gnt_q     <= '0;
            bus_own_q <= 1'b0;
            own_q     <= '0;
            rr_ptr_q  <= '0;
            burst_q   <= '0;
            turn_q    <= '0;
            slot_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nbusrq_q  <= nbusrq_d;
            gnt_q     <= gnt_d;
            bus_own_q <= bus_own_d;
            own_q     <= own_d;
            rr_ptr_q  <= rr_ptr_d;
            burst_q   <= burst_d;
            turn_q    <= turn_d;
            slot_q    <= slot_d;
            expired_q <= expired_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.nBUSRQ  = nbusrq_q;
    assign bus.bus_own = bus_own_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
module tb_z80_bus_arbiter;
    localparam int NREQ        = 2;
    localparam int MAX_BURST   = 16;
    localparam int TURN_CYCLES = 1;
    localparam int CPU_SLOT    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    z80_bus_arbiter_if #(.NREQ(NREQ)) bus ();

    z80_bus_arbiter #(
        .NREQ(NREQ), .MAX_BURST(MAX_BURST),
        .TURN_CYCLES(TURN_CYCLES), .CPU_SLOT(CPU_SLOT)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .bus(bus.master)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Bus ownership described as: who asks the CPU, who holds the bus,
    // how long they have held it, and how much CPU time is still owed.
    bit m_rq, m_rel, m_dma, m_exp;
    int m_owner, m_used, m_gap, m_hold, m_next;

    function automatic int pick(input int rv);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_next + k) % NREQ;
            if (((rv >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int rv;
        int w;
        if (rst) begin
            m_rq = 0; m_rel = 0; m_dma = 0; m_exp = 0;
            m_owner = -1; m_used = 0; m_gap = 0; m_hold = 0; m_next = 0;
        end else begin
            rv = int'(bus.req);
            if (m_rel) begin
                if (bus.nBUSACK) begin m_rel = 0; m_hold = CPU_SLOT; end
            end else if (!m_rq) begin
                if (m_hold > 0) m_hold--;
                else if (rv != 0) m_rq = 1;
            end else if (!m_dma) begin
                if (!bus.nBUSACK) begin
                    w = pick(rv);
                    if (w >= 0) begin m_owner = w; m_dma = 1; m_used = 1; end
                    else begin m_rq = 0; m_rel = 1; end
                end
            end else if (m_owner >= 0) begin
                if (((rv >> m_owner) & 1) == 0 || m_used == MAX_BURST) begin
                    m_exp   = ((rv >> m_owner) & 1) != 0;
                    m_next  = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_gap   = 1;
                end else m_used++;
            end else begin
                if (m_gap < TURN_CYCLES) m_gap++;
                else begin
                    w = m_exp ? -1 : pick(rv);
                    if (w >= 0) begin m_owner = w; m_used = 1; end
                    else begin m_rq = 0; m_dma = 0; m_rel = 1; end
                end
            end
        end
    end

    // ---------------- compare + monitors ----------------
    bit chk_on = 0;
    int cyc = 0;
    int cnt_gnt [NREQ];
    int run_len, max_run, rq_high_cnt;
    logic [NREQ-1:0] prev_gnt = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && chk_on) begin
            chk("model_nbusrq", 32'(bus.nBUSRQ), 32'(!m_rq));
            chk("model_gnt", 32'(bus.gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("model_bus_own", 32'(bus.bus_own), 32'(m_dma));
            chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            if (bus.gnt != '0) chk("gnt_implies_own_ack", {30'd0, bus.bus_own, bus.nBUSACK}, 32'd2);
            if (bus.nBUSRQ) chk("own_low_when_rq_high", 32'(bus.bus_own), 32'd0);
        end
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) if (((int'(bus.gnt) >> i) & 1) != 0) cnt_gnt[i]++;
            if (bus.gnt != '0 && bus.gnt == prev_gnt) run_len++;
            else if (bus.gnt != '0) run_len = 1;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (bus.nBUSRQ) rq_high_cnt++;
            prev_gnt = bus.gnt;
        end
    end

    task automatic zero_mon();
        for (int i = 0; i < NREQ; i++) cnt_gnt[i] = 0;
        max_run = 0; rq_high_cnt = 0;
    endtask

    // ---------------- CPU pin model ----------------
    int ack_dly = 3, ack_cnt = 0, ack_fall_cyc = 0, ack_rise_cyc = 0;
    bit ack_rand = 0;

    task automatic cpu_tick();
        if (bus.nBUSRQ !== bus.nBUSACK) begin
            ack_cnt++;
            if (ack_cnt > ack_dly) begin
                bus.nBUSACK = bus.nBUSRQ;
                ack_cnt = 0;
                if (bus.nBUSACK) ack_rise_cyc = cyc; else ack_fall_cyc = cyc;
                if (ack_rand) ack_dly = $urandom_range(10, 0);
            end
        end else ack_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cpu_tick();
    endtask

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            0: return 32'(bus.nBUSRQ);
            1: return 32'(bus.nBUSACK);
            2: return 32'(bus.gnt);
            3: return 32'(bus.gnt != '0);
            default: return 32'(bus.bus_own);
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input logic [31:0] val, input int bound);
        int n;
        n = 0;
        while (sample(sel) !== val && n < bound) begin tick(); n++; end
        chk(name, sample(sel), val);
    endtask

    task automatic settle_idle();
        bus.req = '0;
        wait_for("settle_rq_high", 0, 1, 60);
        wait_for("settle_ack_high", 1, 1, 20);
        repeat (CPU_SLOT + 3) tick();
    endtask

    initial begin
        logic [NREQ-1:0] r;
        bus.req = '0; bus.nBUSACK = 1'b1; rst = 1'b0;
        zero_mon();

        // Reset / idle
        #2 rst = 1'b1; #1;
        chk("rst_nbusrq", 32'(bus.nBUSRQ), 32'd1);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_bus_own", 32'(bus.bus_own), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; chk_on = 1;
        repeat (5) tick();
        chk("idle_nbusrq", 32'(bus.nBUSRQ), 32'd1);

        // Single short burst: 5 grant cycles, then the 4-cycle CPU slot
        bus.req = 2'b01;
        tick();
        chk("req_to_nbusrq_latency", 32'(bus.nBUSRQ), 32'd0);
        wait_for("short_gnt", 2, 32'd1, 20);
        chk("ack_to_gnt_latency", 32'(cyc - ack_fall_cyc), 32'd1);
        repeat (4) tick();
        bus.req = 2'b00;
        wait_for("short_release", 0, 1, 20);
        chk("short_len", 32'(cnt_gnt[0]), 32'd5);
        bus.req = 2'b01;
        wait_for("short_rereq", 0, 0, 40);
        chk("cpu_slot_gap", 32'(cyc - ack_rise_cyc), 32'(CPU_SLOT + 2));

        // Request withdrawn before the ack
        zero_mon();
        tick();
        bus.req = 2'b00;
        wait_for("wd_ack", 1, 0, 20);
        wait_for("wd_release", 0, 1, 5);
        chk("wd_release_latency", 32'(cyc - ack_fall_cyc), 32'd1);
        chk("wd_no_gnt", 32'(cnt_gnt[0] + cnt_gnt[1]), 32'd0);
        settle_idle();
        chk("wd_idle", 32'(bus.nBUSRQ), 32'd1);

        // Burst limit: two back-to-back 16-cycle tenures separated by a release
        zero_mon();
        bus.req = 2'b10;
        wait_for("bl_gnt", 2, 32'd2, 30);
        wait_for("bl_release", 0, 1, 40);
        chk("bl_len", 32'(cnt_gnt[1]), 32'(MAX_BURST));
        chk("bl_max_run", 32'(max_run), 32'(MAX_BURST));
        wait_for("bl_rereq", 0, 0, 40);
        wait_for("bl_gnt2", 2, 32'd2, 30);
        wait_for("bl_release2", 0, 1, 40);
        chk("bl_len2", 32'(cnt_gnt[1]), 32'(2 * MAX_BURST));
        settle_idle();

        // Round robin chaining
        zero_mon();
        bus.req = 2'b11;
        wait_for("rr_gnt", 3, 1, 30);
        chk("rr_first", 32'(bus.gnt), 32'd1);
        rq_high_cnt = 0;
        repeat (2) tick();
        bus.req = 2'b10;
        tick();
        chk("rr_gap_gnt", 32'(bus.gnt), 32'd0);
        chk("rr_gap_own", 32'(bus.bus_own), 32'd1);
        tick();
        chk("rr_chain_gnt", 32'(bus.gnt), 32'd2);
        chk("rr_no_rq_release", 32'(rq_high_cnt), 32'd0);
        chk("rr_len0", 32'(cnt_gnt[0]), 32'd3);
        settle_idle();
        bus.req = 2'b11;
        wait_for("rr_gnt2", 3, 1, 30);
        chk("rr_again_first", 32'(bus.gnt), 32'd1);

        // Async reset in the middle of a grant
        repeat (2) tick();
        #2 rst = 1'b1; bus.req = '0; #1;
        chk("midrst_nbusrq", 32'(bus.nBUSRQ), 32'd1);
        chk("midrst_gnt", 32'(bus.gnt), 32'd0);
        chk("midrst_bus_own", 32'(bus.bus_own), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) tick();

        // Random traffic with random ack delays
        ack_rand = 1;
        for (int c = 0; c < 10000; c++) begin
            tick();
            r = bus.req;
            for (int i = 0; i < NREQ; i++) begin
                if (((int'(r) >> i) & 1) != 0) begin
                    if ($urandom_range(7, 0) == 0) r = r ^ (NREQ'(1) << i);
                end else if ($urandom_range(5, 0) == 0) r = r ^ (NREQ'(1) << i);
            end
            bus.req = r;
        end
        ack_rand = 0; ack_dly = 3;
        settle_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
